// File: rtl/disp_scan_2dig_if.sv
// -----------------------------------------------------------------------------
// disp_scan_2dig_if
//   Bundle between the two-digit display scanner and whoever drives it.
//
//   Driven by the master (counter side / bench):
//     sa1, sa2   4-bit count values from counter 1 and counter 2
//     en         1 = scan the digits, 0 = blank the display
//     freeze     1 = hold the internal snapshot of sa1/sa2
//     clr        synchronous clear of the equality event counter
//   Driven by the slave (disp_scan_2dig):
//     seg        7-segment pattern {g,f,e,d,c,b,a}, active-high
//     an         digit enables, an[0] = sa1 digit, an[1] = sa2 digit
//     eq_pulse   one-cycle pulse when the two snapshots become equal
//     eq_count   saturating count of equality events (CNT_W bits)
// -----------------------------------------------------------------------------
interface disp_scan_2dig_if #(
  parameter int CNT_W = 8
);
  logic [3:0]       sa1;
  logic [3:0]       sa2;
  logic             en;
  logic             freeze;
  logic             clr;
  logic [6:0]       seg;
  logic [1:0]       an;
  logic             eq_pulse;
  logic [CNT_W-1:0] eq_count;

  modport master (
    output sa1, sa2, en, freeze, clr,
    input  seg, an, eq_pulse, eq_count
  );

  modport slave (
    input  sa1, sa2, en, freeze, clr,
    output seg, an, eq_pulse, eq_count
  );
endinterface

// File: rtl/disp_scan_2dig.sv
// -----------------------------------------------------------------------------
// disp_scan_2dig
//   Snapshots two 4-bit counter values and time-multiplexes them as hex digits
//   onto a shared 7-segment bus. Each digit stays lit for REFRESH_DIV cycles.
//   Also flags the instants the two snapshots become equal (eq_pulse) and keeps
//   a saturating count of those events (eq_count).
//
//   Ports:
//     clock   system clock, all state updates on posedge
//     reset   synchronous, active-low (0 = reset)
//     bus     disp_scan_2dig_if slave modport (sa1/sa2/en/freeze/clr in,
//             seg/an/eq_pulse/eq_count out)
//
//   Parameters:
//     REFRESH_DIV  cycles per digit, 2..256
//     CNT_W        width of the equality event counter
// -----------------------------------------------------------------------------
module disp_scan_2dig #(
  parameter int REFRESH_DIV = 4,
  parameter int CNT_W       = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  disp_scan_2dig_if.slave        bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIG0 = 2'd1,
    DIG1 = 2'd2
  } state_t;

  // Hex digit to {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) r = v;
    else    r = v + 1'b1;
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [3:0]       snap1_q, snap2_q;
  logic             eq_prev_q;
  logic             eq_pulse_q;
  logic [CNT_W-1:0] eq_count_q;
  logic             eq_now;
  logic             eq_rise;
  logic [6:0]       seg_d;
  logic [1:0]       an_d;

  assign eq_now  = (snap1_q == snap2_q);
  assign eq_rise = eq_now & ~eq_prev_q;

  // ---- Stage 1: snapshot of the counter values ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      snap1_q <= 4'd0;
      snap2_q <= 4'd0;
    end else if (!bus.freeze) begin
      snap1_q <= bus.sa1;
      snap2_q <= bus.sa2;
    end
  end

  // ---- Stage 2: equality edge detector and event counter ----
  // eq_prev resets to 1 because the reset snapshots are 0 == 0; this keeps the
  // reset state itself from looking like a new equality event.
  always_ff @(posedge clock) begin
    if (!reset) begin
      eq_prev_q  <= 1'b1;
      eq_pulse_q <= 1'b0;
      eq_count_q <= '0;
    end else begin
      eq_prev_q  <= eq_now;
      eq_pulse_q <= eq_rise;
      // clr wins over a coincident increment; the pulse itself still fires
      if (bus.clr)      eq_count_q <= '0;
      else if (eq_rise) eq_count_q <= sat_inc(eq_count_q);
    end
  end

  // ---- Scan FSM: state register ----
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
    end
  end

  // ---- Scan FSM: next state ----
  // Dropping en abandons the current digit immediately.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    if (!bus.en) begin
      state_d = IDLE;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = DIG0;
          presc_d = '0;
        end
        DIG0: begin
          if (presc_q == PRESC_LAST) begin
            state_d = DIG1;
            presc_d = '0;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        DIG1: begin
          if (presc_q == PRESC_LAST) begin
            state_d = DIG0;
            presc_d = '0;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          presc_d = '0;
        end
      endcase
    end
  end

  // ---- Display outputs: decoded from registered state and snapshot ----
  always_comb begin
    an_d  = 2'b00;
    seg_d = 7'h00;
    case (state_q)
      DIG0: begin
        an_d  = 2'b01;
        seg_d = hex_seg(snap1_q);
      end
      DIG1: begin
        an_d  = 2'b10;
        seg_d = hex_seg(snap2_q);
      end
      default: begin
        an_d  = 2'b00;
        seg_d = 7'h00;
      end
    endcase
  end

  assign bus.an       = an_d;
  assign bus.seg      = seg_d;
  assign bus.eq_pulse = eq_pulse_q;
  assign bus.eq_count = eq_count_q;

endmodule
